// File: rtl/dz_pkg.sv
// Shared definitions for the dual-bank LED matrix scanner.
// Holds the width helpers, the active-low row-select encoder and the
// all-off output constants used by dz_matrix_scan and dz_frame_buf.
package dz_pkg;

    // Upper bounds of the supported geometry; encoder and constants are
    // sized to these and truncated by the users to the real ROWS/COLS.
    localparam int ROWS_MAX = 16;
    localparam int COLS_MAX = 32;

    // Row select idles high (no row driven), columns idle low (no LED lit).
    localparam logic [ROWS_MAX-1:0] ROW_OFF = '1;
    localparam logic [COLS_MAX-1:0] COL_OFF = '0;

    // ceil(log2(n)) but never below 1, so a counter always has one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a row address for a matrix with the given number of rows.
    function automatic int rw_width(input int rows);
        return clog2_min1(rows);
    endfunction

    // Active-low one-hot row select: bit idx low, every other bit high.
    function automatic logic [ROWS_MAX-1:0] row_sel_n(input logic [3:0] idx);
        return ~(ROWS_MAX'(1) << idx);
    endfunction

endpackage

// File: rtl/dz_frame_buf.sv
// Dual-bank frame store: two banks of ROWS x (red COLS + green COLS) bits.
// Ports: clk/rst, one synchronous write port (bank, row, red, green) and two
// combinational read ports sharing a row address, one per bank.
module dz_frame_buf #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int RW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic            wr_bank_i,
    input  logic [RW-1:0]   wr_row_i,
    input  logic [COLS-1:0] wr_red_i,
    input  logic [COLS-1:0] wr_grn_i,
    input  logic [RW-1:0]   rd_row_i,
    output logic [COLS-1:0] rd0_red_o,
    output logic [COLS-1:0] rd0_grn_o,
    output logic [COLS-1:0] rd1_red_o,
    output logic [COLS-1:0] rd1_grn_o
);

    logic [COLS-1:0] red_q [2][ROWS];
    logic [COLS-1:0] grn_q [2][ROWS];

    // Addresses beyond the last row are dropped (only possible when ROWS
    // is not a power of two).
    logic wr_ok;
    assign wr_ok = wr_en_i && ({1'b0, wr_row_i} < (RW+1)'(ROWS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    red_q[b][r] <= '0;
                    grn_q[b][r] <= '0;
                end
            end
        end else if (wr_ok) begin
            red_q[wr_bank_i][wr_row_i] <= wr_red_i;
            grn_q[wr_bank_i][wr_row_i] <= wr_grn_i;
        end
    end

    assign rd0_red_o = red_q[0][rd_row_i];
    assign rd0_grn_o = grn_q[0][rd_row_i];
    assign rd1_red_o = red_q[1][rd_row_i];
    assign rd1_grn_o = grn_q[1][rd_row_i];

endmodule

// File: rtl/dz_matrix_scan.sv
// Multiplexed bicolour LED matrix scanner with double-buffered frame store.
// Ports: clk/rst, back-buffer write (wr_en/wr_row/wr_red/wr_grn), swap
// handshake (swap_req/swap_pend/swap_done), registered drive (row/colr/colg,
// frame_start). Optional DZ_BLANK_EN blanks the columns on each row's first
// dwell cycle to suppress ghosting.
module dz_matrix_scan
    import dz_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [rw_width(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]             wr_red,
    input  logic [COLS-1:0]             wr_grn,
    input  logic                        swap_req,
    output logic                        swap_pend,
    output logic                        swap_done,
    output logic                        frame_start,
    output logic [ROWS-1:0]             row,
    output logic [COLS-1:0]             colr,
    output logic [COLS-1:0]             colg
);

    localparam int RW = rw_width(ROWS);
    localparam int DW = clog2_min1(DWELL);

    // Scan position and buffer control
    logic [DW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [RW-1:0]   row_idx_q,   row_idx_d;
    logic            front_sel_q, front_sel_d;
    logic            swap_pend_q, swap_pend_d;

    // Registered outputs
    logic            swap_done_q,   swap_done_d;
    logic            frame_start_q, frame_start_d;
    logic [ROWS-1:0] row_q,  row_d;
    logic [COLS-1:0] colr_q, colr_d;
    logic [COLS-1:0] colg_q, colg_d;

    logic [COLS-1:0] b0_red, b0_grn, b1_red, b1_grn;
    logic [COLS-1:0] front_red, front_grn;

    logic dwell_last, row_last, frame_end, do_swap;

    // Writes always go to the bank not being displayed. At a swapping frame
    // end the write still targets the pre-swap back bank, which becomes the
    // front bank on that same edge, so the data shows in the very next frame.
    dz_frame_buf #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW)
    ) u_frame_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_bank_i (~front_sel_q),
        .wr_row_i  (wr_row),
        .wr_red_i  (wr_red),
        .wr_grn_i  (wr_grn),
        .rd_row_i  (row_idx_q),
        .rd0_red_o (b0_red),
        .rd0_grn_o (b0_grn),
        .rd1_red_o (b1_red),
        .rd1_grn_o (b1_grn)
    );

    assign front_red = front_sel_q ? b1_red : b0_red;
    assign front_grn = front_sel_q ? b1_grn : b0_grn;

    assign dwell_last = (dwell_cnt_q == DW'(DWELL - 1));
    assign row_last   = (row_idx_q   == RW'(ROWS - 1));
    assign frame_end  = dwell_last && row_last;
    // front_sel only moves here, so a frame is never torn between banks.
    assign do_swap    = frame_end && swap_pend_q;

    always_comb begin
        dwell_cnt_d = dwell_last ? '0 : dwell_cnt_q + 1'b1;

        row_idx_d = row_idx_q;
        if (dwell_last) begin
            row_idx_d = row_last ? '0 : row_idx_q + 1'b1;
        end

        front_sel_d = do_swap ? ~front_sel_q : front_sel_q;

        // A request on the swapping edge re-arms the pending flag, so exactly
        // one more swap follows at the next frame end; requests while already
        // pending fold into the existing one.
        swap_pend_d = swap_req || (swap_pend_q && !frame_end);
        swap_done_d = do_swap;

        // Outputs show the position the counters hold now, one cycle later.
        frame_start_d = (row_idx_q == '0) && (dwell_cnt_q == '0);
        row_d         = ROWS'(row_sel_n(4'(row_idx_q)));
        colr_d        = front_red;
        colg_d        = front_grn;
`ifdef DZ_BLANK_EN
        // Dark first dwell slot of every row while the row drivers settle.
        if (dwell_cnt_q == '0) begin
            colr_d = '0;
            colg_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt_q   <= '0;
            row_idx_q     <= '0;
            front_sel_q   <= 1'b0;
            swap_pend_q   <= 1'b0;
            swap_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            row_q         <= ROWS'(ROW_OFF);
            colr_q        <= COLS'(COL_OFF);
            colg_q        <= COLS'(COL_OFF);
        end else begin
            dwell_cnt_q   <= dwell_cnt_d;
            row_idx_q     <= row_idx_d;
            front_sel_q   <= front_sel_d;
            swap_pend_q   <= swap_pend_d;
            swap_done_q   <= swap_done_d;
            frame_start_q <= frame_start_d;
            row_q         <= row_d;
            colr_q        <= colr_d;
            colg_q        <= colg_d;
        end
    end

    assign swap_pend   = swap_pend_q;
    assign swap_done   = swap_done_q;
    assign frame_start = frame_start_q;
    assign row         = row_q;
    assign colr        = colr_q;
    assign colg        = colg_q;

endmodule

// File: tb/tb_dz_matrix_scan.sv
// Scoreboard bench for dz_matrix_scan (ROWS=8, COLS=8, DWELL=4).
// The driver predicts each cycle's outputs from frame-position arithmetic and
// queues them; the monitor compares one entry per clock, 1 time unit after it.
module tb_dz_matrix_scan;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DWELL = 4;
    localparam int FRAME = ROWS * DWELL;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_row = '0;
    logic [COLS-1:0] wr_red = '0;
    logic [COLS-1:0] wr_grn = '0;
    logic            swap_req = 1'b0;
    logic            swap_pend, swap_done, frame_start;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] colr, colg;

    dz_matrix_scan #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_red      (wr_red),
        .wr_grn      (wr_grn),
        .swap_req    (swap_req),
        .swap_pend   (swap_pend),
        .swap_done   (swap_done),
        .frame_start (frame_start),
        .row         (row),
        .colr        (colr),
        .colg        (colg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] colr;
        logic [COLS-1:0] colg;
        logic            fs;
        logic            sp;
        logic            sd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: frame contents, displayed bank, pending flag, and the
    // number of scan cycles since reset released.
    logic [COLS-1:0] m_red [2][ROWS];
    logic [COLS-1:0] m_grn [2][ROWS];
    int              m_front;
    logic            m_pend;
    int              m_t;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) begin
                m_red[b][r] = '0;
                m_grn[b][r] = '0;
            end
        m_front = 0;
        m_pend  = 1'b0;
        m_t     = 0;
    endtask

    // Predict what the outputs show after the coming edge, then apply the
    // inputs of this cycle to the reference state.
    task automatic model_cycle(input logic we, input int wr, input logic [COLS-1:0] r,
                               input logic [COLS-1:0] g, input logic sw);
        exp_t e;
        int   p, cur_row, cur_dw;
        logic [ROWS-1:0] one;
        p       = m_t % FRAME;
        cur_row = p / DWELL;
        cur_dw  = p % DWELL;
        one     = 1;
        e.row   = ~(one << cur_row);
        e.colr  = m_red[m_front][cur_row];
        e.colg  = m_grn[m_front][cur_row];
`ifdef DZ_BLANK_EN
        if (cur_dw == 0) begin
            e.colr = '0;
            e.colg = '0;
        end
`endif
        e.fs = (p == 0);
        e.sd = (p == FRAME - 1) && m_pend;
        if (we && wr < ROWS) begin
            m_red[1 - m_front][wr] = r;
            m_grn[1 - m_front][wr] = g;
        end
        if (p == FRAME - 1 && m_pend) begin
            m_front = 1 - m_front;
            m_pend  = 1'b0;
        end
        if (sw) m_pend = 1'b1;
        e.sp = m_pend;
        m_t++;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic we, input int wr, input logic [COLS-1:0] r,
                        input logic [COLS-1:0] g, input logic sw);
        @(negedge clk);
        rst      = 1'b0;
        wr_en    = we;
        wr_row   = 3'(wr);
        wr_red   = r;
        wr_grn   = g;
        swap_req = sw;
        model_cycle(we, wr, r, g, sw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, '0, 1'b0);
    endtask

    // Idle until the next driven cycle sits at frame position p.
    task automatic run_to(input int p);
        while (m_t % FRAME != p) step(1'b0, 0, '0, '0, 1'b0);
    endtask

    task automatic hold_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst      = 1'b1;
            wr_en    = 1'b0;
            swap_req = 1'b0;
            model_reset();
            e.row  = '1;
            e.colr = '0;
            e.colg = '0;
            e.fs   = 1'b0;
            e.sp   = 1'b0;
            e.sd   = 1'b0;
            exp_q.push_back(e);
            if (i == 0) begin
                // Asynchronous reset must blank the outputs before any edge.
                #1;
                n_checks++;
                if (row !== '1 || colr !== '0 || colg !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset: got row=%h colr=%h colg=%h want row=ff colr=00 colg=00",
                             row, colr, colg);
                end
            end
        end
    endtask

    // Monitor: one comparison per clock whenever a prediction is queued.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e, a;
                e = exp_q.pop_front();
                a = '{row: row, colr: colr, colg: colg, fs: frame_start,
                      sp: swap_pend, sd: swap_done};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got row=%h r=%h g=%h fs=%b sp=%b sd=%b want row=%h r=%h g=%h fs=%b sp=%b sd=%b",
                             $time, a.row, a.colr, a.colg, a.fs, a.sp, a.sd,
                             e.row, e.colr, e.colg, e.fs, e.sp, e.sd);
                end
            end
        end
    end

    initial begin
        model_reset();
        hold_reset(3);

        // Blank display scans all rows, frame_start every frame.
        idle(40);

        // Back-bank write stays invisible until a swap completes.
        step(1'b1, 3, 8'h7E, 8'h00, 1'b0);
        idle(FRAME + 5);
        step(1'b0, 0, '0, '0, 1'b1);
        idle(2 * FRAME);

        // Request on the swapping frame-end cycle re-arms one more swap.
        step(1'b0, 0, '0, '0, 1'b1);
        run_to(FRAME - 1);
        step(1'b0, 0, '0, '0, 1'b1);
        idle(2 * FRAME + 4);

        // Write on the swapping edge is visible in the very next frame.
        step(1'b0, 0, '0, '0, 1'b1);
        run_to(FRAME - 1);
        step(1'b1, 5, 8'h00, 8'h3C, 1'b0);
        idle(FRAME + 2);

        // Fill all rows red and show them.
        for (int r = 0; r < ROWS; r++) step(1'b1, r, 8'hFF, 8'h00, 1'b0);
        step(1'b0, 0, '0, '0, 1'b1);
        run_to(0);
        idle(FRAME + 3);

        // Reset while row 4 (EF) is lit, then confirm banks were cleared.
        run_to(4 * DWELL + 1);
        hold_reset(2);
        idle(10);
        step(1'b0, 0, '0, '0, 1'b1);
        run_to(0);
        idle(FRAME + 1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 3), int'($urandom_range(0, ROWS - 1)),
                 COLS'($urandom), COLS'($urandom), ($urandom_range(0, 19) == 0));
        end
        idle(2);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued predictions, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
